// File: rtl/ram_stream_loader_if.sv
// Byte-stream handshake and block-RAM port bundle for ram_stream_loader.
// The loader is the master on both: it consumes bytes and initiates RAM cycles.
interface ram_stream_loader_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_ce;
  logic              mem_oce;
  logic              mem_wre;
  logic [ADDR_W-1:0] mem_ad;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport master (
    input  in_valid, in_data, mem_dout,
    output in_ready, mem_ce, mem_oce, mem_wre, mem_ad, mem_din
  );

  modport slave (
    output in_valid, in_data, mem_dout,
    input  in_ready, mem_ce, mem_oce, mem_wre, mem_ad, mem_din
  );
endinterface

// File: rtl/ram_stream_loader.sv
// Loads a byte stream into the program RAM as little-endian 16-bit words,
// then reads the image back and compares read/write checksums.
module ram_stream_loader #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W:0]     word_count,
  ram_stream_loader_if.master bus,
  output logic                busy,
  output logic                cpu_halt,
  output logic                done,
  output logic                error,
  output logic [DATA_W-1:0]   wr_sum,
  output logic [DATA_W-1:0]   rd_sum
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LO     = 3'd1;
  localparam logic [2:0] HI     = 3'd2;
  localparam logic [2:0] WR     = 3'd3;
  localparam logic [2:0] VRD    = 3'd4;
  localparam logic [2:0] VDRAIN = 3'd5;
  localparam logic [2:0] VCMP   = 3'd6;
  localparam logic [2:0] DONE   = 3'd7;

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(1) << ADDR_W;

  logic [2:0]        state;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_clamped;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        lo;
  logic              pend;
  logic              last;
  logic              ce;
  logic              wre;
  logic [ADDR_W-1:0] ad;
  logic [DATA_W-1:0] din;

  assign cnt_clamped = (word_count > MAX_CNT) ? MAX_CNT : word_count;
  assign last        = ({1'b0, addr} == (cnt - (ADDR_W+1)'(1)));

  assign bus.in_ready = (state == LO) || (state == HI);
  assign bus.mem_ce   = ce;
  assign bus.mem_oce  = 1'b1;
  assign bus.mem_wre  = wre;
  assign bus.mem_ad   = ad;
  assign bus.mem_din  = din;
  assign cpu_halt     = busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      addr   <= '0;
      lo     <= '0;
      pend   <= 1'b0;
      ce     <= 1'b0;
      wre    <= 1'b0;
      ad     <= '0;
      din    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
      wr_sum <= '0;
      rd_sum <= '0;
    end else begin
      // pend marks the cycle after a read was issued, when mem_dout is valid
      pend <= 1'b0;
      if (pend) begin
        rd_sum <= rd_sum + bus.mem_dout;
      end

      case (state)
        IDLE: begin
          if (start) begin
            cnt    <= cnt_clamped;
            addr   <= '0;
            wr_sum <= '0;
            rd_sum <= '0;
            error  <= 1'b0;
            done   <= 1'b0;
            busy   <= 1'b1;
            state  <= (cnt_clamped == '0) ? DONE : LO;
          end
        end
        LO: begin
          if (bus.in_valid) begin
            lo    <= bus.in_data;
            state <= HI;
          end
        end
        HI: begin
          // RAM controls are registered, so they are set up on entry to WR
          if (bus.in_valid) begin
            ce    <= 1'b1;
            wre   <= 1'b1;
            ad    <= addr;
            din   <= {bus.in_data, lo};
            state <= WR;
          end
        end
        WR: begin
          wr_sum <= wr_sum + din;
          wre    <= 1'b0;
          if (last) begin
            addr  <= '0;
            ce    <= 1'b1;
            ad    <= '0;
            state <= VRD;
          end else begin
            addr  <= addr + ADDR_W'(1);
            ce    <= 1'b0;
            state <= LO;
          end
        end
        VRD: begin
          pend <= 1'b1;
          if (last) begin
            ce    <= 1'b0;
            state <= VDRAIN;
          end else begin
            addr <= addr + ADDR_W'(1);
            ad   <= addr + ADDR_W'(1);
          end
        end
        VDRAIN: begin
          state <= VCMP;
        end
        VCMP: begin
          error <= (rd_sum != wr_sum);
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_loader.sv
// Directed bench for ram_stream_loader with a behavioural 2048x16 RAM
// that can corrupt one readback word.
module tb_ram_stream_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] word_count;
  logic        busy, cpu_halt, done, error;
  logic [15:0] wr_sum, rd_sum;

  int checks   = 0;
  int failures = 0;

  ram_stream_loader_if #(.ADDR_W(11), .DATA_W(16)) bus ();

  ram_stream_loader #(.ADDR_W(11), .DATA_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .bus        (bus),
    .busy       (busy),
    .cpu_halt   (cpu_halt),
    .done       (done),
    .error      (error),
    .wr_sum     (wr_sum),
    .rd_sum     (rd_sum)
  );

  always #5 clk = ~clk;

  logic [15:0] ram [0:2047];
  logic        corrupt;

  always @(posedge clk) begin
    if (bus.mem_ce) begin
      if (bus.mem_wre) ram[bus.mem_ad] <= bus.mem_din;
      else bus.mem_dout <= (corrupt && bus.mem_ad == 11'd1) ? 16'h9167 : ram[bus.mem_ad];
    end
  end

  int wr_ad_q[$];
  int wr_din_q[$];
  int rd_ad_q[$];
  int rd_cyc_q[$];
  int cyc         = 0;
  int ce_count    = 0;
  int ready_in_wr = 0;
  int busy_gap    = 0;
  bit op_active   = 0;

  always @(negedge clk) begin
    cyc++;
    if (bus.mem_ce && bus.mem_wre) begin
      wr_ad_q.push_back(int'(bus.mem_ad));
      wr_din_q.push_back(int'(bus.mem_din));
    end
    if (bus.mem_ce && !bus.mem_wre) begin
      rd_ad_q.push_back(int'(bus.mem_ad));
      rd_cyc_q.push_back(cyc);
    end
    if (bus.mem_ce) ce_count++;
    if (bus.in_ready && bus.mem_wre) ready_in_wr++;
    if (op_active && !busy && !done) busy_gap++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    wr_ad_q.delete();
    wr_din_q.delete();
    rd_ad_q.delete();
    rd_cyc_q.delete();
    ce_count    = 0;
    ready_in_wr = 0;
    busy_gap    = 0;
  endtask

  task automatic pulse_start(input int n);
    start      = 1'b1;
    word_count = 12'(n);
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    bus.in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!bus.in_ready) check("byte_handshake_timeout", bus.in_ready, 1);
    else begin @(posedge clk); #1; end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (!done && n < max_cycles) begin @(posedge clk); #1; n++; end
    check(tag, done, 1);
  endtask

  logic [7:0] t4_bytes [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  int         t4_gap   [6] = '{3, 0, 5, 1, 2, 4};

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    word_count   = '0;
    corrupt      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_mem_ce", bus.mem_ce, 0);
    check("rst_mem_wre", bus.mem_wre, 0);
    check("rst_mem_ad", bus.mem_ad, 0);
    check("rst_mem_din", bus.mem_din, 0);
    check("rst_mem_oce", bus.mem_oce, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_sums", {wr_sum, rd_sum}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Test 1: two words, continuous stream
    clear_logs();
    pulse_start(2);
    op_active = 1;
    check("t1_busy", busy, 1);
    check("t1_cpu_halt", cpu_halt, 1);
    send_byte(8'hA1, 0); send_byte(8'h78, 0);
    send_byte(8'h66, 0); send_byte(8'h91, 0);
    wait_done("t1_done", 20);
    op_active = 0;
    check("t1_busy_gap", busy_gap, 0);
    check("t1_wr_count", wr_ad_q.size(), 2);
    check("t1_wr0_ad", wr_ad_q[0], 0);
    check("t1_wr0_din", wr_din_q[0], 32'h78A1);
    check("t1_wr1_ad", wr_ad_q[1], 1);
    check("t1_wr1_din", wr_din_q[1], 32'h9166);
    check("t1_wr_sum", wr_sum, 16'h0A07);
    check("t1_rd_sum", rd_sum, 16'h0A07);
    check("t1_error", error, 0);
    check("t1_busy_end", busy, 0);

    // Test 2: RAM corrupts word 1 on readback
    corrupt = 1'b1;
    clear_logs();
    pulse_start(2);
    send_byte(8'hA1, 0); send_byte(8'h78, 0);
    send_byte(8'h66, 0); send_byte(8'h91, 0);
    wait_done("t2_done", 20);
    check("t2_wr_sum", wr_sum, 16'h0A07);
    check("t2_rd_sum", rd_sum, 16'h0A08);
    check("t2_error", error, 1);
    corrupt = 1'b0;

    // Test 3: zero-length load
    clear_logs();
    pulse_start(0);
    check("t3_done_cleared", done, 0);
    wait_done("t3_done", 2);
    check("t3_no_ce", ce_count, 0);
    check("t3_sums", {wr_sum, rd_sum}, 0);
    check("t3_error", error, 0);

    // Test 4: three words with gaps in the byte stream
    clear_logs();
    pulse_start(3);
    for (int i = 0; i < 6; i++) send_byte(t4_bytes[i], t4_gap[i]);
    wait_done("t4_done", 30);
    check("t4_ready_in_wr", ready_in_wr, 0);
    check("t4_wr_count", wr_ad_q.size(), 3);
    check("t4_wr0", {wr_ad_q[0][15:0], wr_din_q[0][15:0]}, {16'd0, 16'h2211});
    check("t4_wr1", {wr_ad_q[1][15:0], wr_din_q[1][15:0]}, {16'd1, 16'h4433});
    check("t4_wr2", {wr_ad_q[2][15:0], wr_din_q[2][15:0]}, {16'd2, 16'h6655});
    check("t4_rd_count", rd_ad_q.size(), 3);
    check("t4_rd_ads", {rd_ad_q[0][7:0], rd_ad_q[1][7:0], rd_ad_q[2][7:0]}, 24'h000102);
    check("t4_rd_consec1", rd_cyc_q[1] - rd_cyc_q[0], 1);
    check("t4_rd_consec2", rd_cyc_q[2] - rd_cyc_q[1], 1);
    check("t4_sums", {wr_sum, rd_sum}, {16'hCC99, 16'hCC99});
    check("t4_error", error, 0);

    // Test 5: reset in the middle of a 4-word load
    pulse_start(4);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("t5_busy", busy, 0);
    check("t5_in_ready", bus.in_ready, 0);
    check("t5_mem_wre", bus.mem_wre, 0);
    check("t5_done", done, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    clear_logs();
    pulse_start(1);
    send_byte(8'h34, 0); send_byte(8'h12, 0);
    wait_done("t5_done_new", 20);
    check("t5_wr_count", wr_ad_q.size(), 1);
    check("t5_wr0", {wr_ad_q[0][15:0], wr_din_q[0][15:0]}, {16'd0, 16'h1234});
    check("t5_sums", {wr_sum, rd_sum}, {16'h1234, 16'h1234});

    // Test 6: oversized count clamps to 2048, restart while busy ignored
    clear_logs();
    pulse_start(4095);
    for (int i = 0; i < 4096; i++) begin
      send_byte(8'(i), 0);
      if (i == 9) begin
        pulse_start(5);
        check("t6_busy_after_restart", busy, 1);
      end
    end
    wait_done("t6_done", 3000);
    check("t6_wr_count", wr_ad_q.size(), 2048);
    if (wr_ad_q.size() > 0) begin
      check("t6_last_wr_ad", wr_ad_q[wr_ad_q.size()-1], 32'h7FF);
      check("t6_last_wr_din", wr_din_q[wr_din_q.size()-1], 32'hFFFE);
    end
    check("t6_rd_count", rd_ad_q.size(), 2048);
    if (rd_ad_q.size() > 0) check("t6_last_rd_ad", rd_ad_q[rd_ad_q.size()-1], 32'h7FF);
    check("t6_wr_sum", wr_sum, 16'hF800);
    check("t6_rd_sum", rd_sum, 16'hF800);
    check("t6_error", error, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
